// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that gives one of N write requesters access to an
//   8-bit sync FIFO for a burst of up to MAX_BURST beats.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[N]       requester has a beat ready
//   data_in      packed requester data, slice i = [i*DW +: DW]
//   last[N]      end-of-burst marker, qualified by req[i]
//   full         FIFO full
//   gnt[N]       registered one-hot grant (or zero)
//   ack[N]       combinational beat-accepted strobe for the granted requester
//   wr_en        FIFO write enable
//   data_out     FIFO write data (granted slice, zero when nothing is granted)

// Per-requester slice: accept strobe and grant-masked data.
module fifo_wr_arbiter_lane #(
  parameter int DW = 8
) (
  input  logic          i_gnt,
  input  logic          i_req,
  input  logic          i_full,
  input  logic [DW-1:0] i_data,
  output logic          o_ack,
  output logic [DW-1:0] o_data
);
  assign o_ack  = i_gnt & i_req & ~i_full;
  assign o_data = i_gnt ? i_data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N*DW-1:0] data_in,
  input  logic [N-1:0]  last,
  input  logic          full,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  ack,
  output logic          wr_en,
  output logic [DW-1:0] data_out
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic [IW-1:0]   r_gidx;
  logic [IW-1:0]   r_last_gnt;
  logic [CW-1:0]   r_cnt;

  logic [N-1:0][DW-1:0] w_lane_data;
  logic [N-1:0]    w_ack;
  logic [DW-1:0]   w_dout;
  logic [IW-1:0]   w_j;
  logic [IW-1:0]   w_pick;
  logic [N-1:0]    w_pick_oh;
  logic            w_any;
  logic            w_req_g;
  logic            w_last_g;
  logic            w_acc;
  logic            w_cap;
  logic            w_rel;

  for (genvar i = 0; i < N; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DW(DW)) u_lane (
      .i_gnt  (r_gnt[i]),
      .i_req  (req[i]),
      .i_full (full),
      .i_data (data_in[i*DW +: DW]),
      .o_ack  (w_ack[i]),
      .o_data (w_lane_data[i])
    );
  end

  // At most one lane is granted, so OR-ing the masked slices is the mux.
  always_comb begin
    w_dout = '0;
    for (int i = 0; i < N; i++) w_dout = w_dout | w_lane_data[i];
  end

  // Rotating priority: start one past the last granted requester, wrap.
  always_comb begin
    w_any     = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    w_j       = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(r_last_gnt) + k) % N);
      if (!w_any && req[w_j]) begin
        w_any          = 1'b1;
        w_pick         = w_j;
        w_pick_oh[w_j] = 1'b1;
      end
    end
  end

  assign w_req_g  = |(req & r_gnt);
  assign w_last_g = |(last & r_gnt);
  assign w_acc    = |w_ack;
  assign w_cap    = (r_cnt == CW'(MAX_BURST - 1));
  // Release on last beat, on the MAX_BURST-th beat, or when the owner withdraws.
  assign w_rel    = !w_req_g || (w_acc && (w_last_g || w_cap));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_last_gnt <= IW'(N - 1);
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick_oh;
            r_gidx  <= w_pick;
            r_cnt   <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_acc) r_cnt <= r_cnt + CW'(1);
          if (w_rel) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_last_gnt <= r_gidx;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign ack      = w_ack;
  assign wr_en    = w_acc;
  assign data_out = w_dout;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0][DW-1:0] d;
  logic [N*DW-1:0]   data_in;
  logic [N-1:0]      last;
  logic              full;
  logic [N-1:0]      gnt;
  logic [N-1:0]      ack;
  logic              wr_en;
  logic [DW-1:0]     data_out;

  typedef struct {
    int          idx;
    logic [7:0]  dat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  assign data_in = d;

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .last     (last),
    .full     (full),
    .gnt      (gnt),
    .ack      (ack),
    .wr_en    (wr_en),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] dat);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    full  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every FIFO write must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(gnt)) begin
        checks++;
        errors++;
        $display("FAIL gnt_onehot: got %b", gnt);
      end
      if (wr_en) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: data %0h ack %b at %0t", data_out, ack, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (data_out !== e.dat || ack !== N'(1 << e.idx) || full !== 1'b0) begin
            errors++;
            $display("FAIL write: got data %0h ack %b full %b expected data %0h ack %b at %0t",
                     data_out, ack, full, e.dat, N'(1 << e.idx), $time);
          end
        end
      end else if (ack !== '0) begin
        checks++;
        errors++;
        $display("FAIL ack_without_write: ack %b at %0t", ack, $time);
      end
    end
  end

  initial begin
    // Reset state, with requests present so a stuck grant would show.
    rst_n = 1'b0;
    req   = '1;
    last  = '0;
    full  = 1'b0;
    d     = '0;
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data_out", 32'(data_out), 0);
    do_reset();

    // Single burst on requester 0.
    req = 4'b0001; d[0] = 8'hA1;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    tick(); chk("s1_gnt", 32'(gnt), 32'h1);
    tick(); d[0] = 8'hA2;
    tick(); d[0] = 8'hA3; last = 4'b0001;
    tick(); req = '0; last = '0;
    chk("s1_release", 32'(gnt), 0);

    // Round robin from a fresh reset.
    do_reset();
    req = '1; last = '1;
    for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      push(k % N, 8'(8'h10 + (k % N)));
      tick(); chk("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
      tick(); chk("rr_idle", 32'(gnt), 0);
    end
    req = '0; last = '0;

    // Full stall on requester 2 (last granted was 0).
    req = 4'b0100; full = 1'b1; last = 4'b0100; d[2] = 8'hC5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_gnt", 32'(gnt), 32'h4);
      chk("stall_wr_en", 32'(wr_en), 0);
      chk("stall_ack", 32'(ack), 0);
    end
    tick(); full = 1'b0; push(2, 8'hC5);
    tick(); req = '0; last = '0;
    chk("stall_release", 32'(gnt), 0);

    // Burst cap: requester 1 streams 20 beats; requester 0 cuts in at 16.
    req = 4'b0010; d[1] = 8'h20;
    for (int b = 0; b < 16; b++) push(1, 8'(8'h20 + b));
    tick(); chk("cap_gnt", 32'(gnt), 32'h2);
    req[0] = 1'b1; last[0] = 1'b1; d[0] = 8'h55;
    for (int b = 1; b < 16; b++) begin
      tick(); d[1] = 8'(8'h20 + b);
    end
    tick(); chk("cap_release", 32'(gnt), 0);
    d[1] = 8'h30; push(0, 8'h55);
    tick(); chk("cap_other_first", 32'(gnt), 32'h1);
    tick(); req[0] = 1'b0; last[0] = 1'b0;
    tick(); chk("cap_resume", 32'(gnt), 32'h2);
    for (int b = 0; b < 4; b++) push(1, 8'(8'h30 + b));
    for (int b = 1; b < 4; b++) begin
      tick(); d[1] = 8'(8'h30 + b);
    end
    tick(); req = '0;
    tick(); chk("cap_withdraw", 32'(gnt), 0);

    // Withdraw by requester 3; last_gnt=3 makes requester 0 win next.
    req = 4'b1000; d[3] = 8'hD0;
    push(3, 8'hD0); push(3, 8'hD1);
    tick(); chk("wd_gnt", 32'(gnt), 32'h8);
    tick(); d[3] = 8'hD1;
    tick(); req = '0;
    chk("wd_hold", 32'(gnt), 32'h8);
    tick(); chk("wd_release", 32'(gnt), 0);
    req = 4'b1001; last = 4'b0001; d[0] = 8'h44; push(0, 8'h44);
    tick(); chk("wd_next_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; last = '0;

    // Reset mid-burst on requester 2.
    req = 4'b0100; d[2] = 8'h66; push(2, 8'h66);
    tick(); chk("mr_gnt", 32'(gnt), 32'h4);
    tick(); d[2] = 8'h67;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt_async", 32'(gnt), 0);
    chk("mr_wr_en_async", 32'(wr_en), 0);
    chk("mr_data_async", 32'(data_out), 0);
    req = '1; last = '1; d[0] = 8'h77;
    tick(); chk("mr_gnt_held", 32'(gnt), 0);
    rst_n = 1'b1;
    push(0, 8'h77);
    tick(); chk("mr_first_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; last = '0;
    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
